// File: rtl/bird_game_ctrl_pkg.sv
// Shared definitions for the bird game sequencer and the blocks around it.
//   game_state_t  : state encoding (also the value driven on the 2-bit state port)
//   SCORE_W_DEF   : default score width, reused by the score-render block
//   SCORE_MAX_DEF : default score saturation value
//   cnt_width()   : bits needed to hold a counter's load value
package bird_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int SCORE_W_DEF   = 14;
    localparam int SCORE_MAX_DEF = 9999;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bird_game_ctrl_tick_downcounter.sv
// Loadable down-counter decremented by frame ticks, saturating at zero.
// Ports:
//   clk, rst  : clock, async active-high reset (count -> 0)
//   load      : load load_val (wins over dec)
//   load_val  : value to load
//   dec       : decrement request (one frame tick while enabled)
//   is_zero   : count has reached zero
module bird_game_ctrl_tick_downcounter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/bird_game_ctrl.sv
// Top-level game sequencer: IDLE -> PLAY <-> PAUSE, PLAY -> OVER -> PLAY.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   tick                          : one-cycle frame tick
//   start_pulse/flap_pulse/pause_pulse : debounced one-cycle button pulses
//   collide                       : level, bird hits pipe or ground
//   pipe_passed                   : one-cycle pulse, bird cleared a pipe
//   state                         : 0=IDLE 1=PLAY 2=PAUSE 3=OVER
//   run_en                        : physics/world advance enable (PLAY only)
//   flap_req                      : one-cycle accepted-flap pulse
//   clear_world                   : one-cycle world reset pulse
//   score, high_score             : current and best score since reset
module bird_game_ctrl
    import bird_game_ctrl_pkg::*;
#(
    parameter int COOLDOWN_TICKS  = 4,
    parameter int OVER_HOLD_TICKS = 60,
    parameter int SCORE_W         = SCORE_W_DEF,
    parameter int SCORE_MAX       = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start_pulse,
    input  logic               flap_pulse,
    input  logic               pause_pulse,
    input  logic               collide,
    input  logic               pipe_passed,
    output logic [1:0]         state,
    output logic               run_en,
    output logic               flap_req,
    output logic               clear_world,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int CD_W   = cnt_width(COOLDOWN_TICKS);
    localparam int HOLD_W = cnt_width(OVER_HOLD_TICKS);

    game_state_t        state_q, state_n;
    logic [SCORE_W-1:0] score_q, score_n, score_inc;
    logic [SCORE_W-1:0] high_q, high_n;
    logic               flap_q, flap_n;
    logic               clear_q, clear_n;
    logic               run_q;

    logic               cd_load, cd_clr, cd_zero;
    logic               hold_load, hold_zero;

    // Cooldown only runs in PLAY so it stays frozen through PAUSE.
    bird_game_ctrl_tick_downcounter #(.W(CD_W)) u_cooldown (
        .clk      (clk),
        .rst      (rst),
        .load     (cd_load | cd_clr),
        .load_val (cd_clr ? '0 : CD_W'(COOLDOWN_TICKS)),
        .dec      (tick && (state_q == ST_PLAY)),
        .is_zero  (cd_zero)
    );

    bird_game_ctrl_tick_downcounter #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_W'(OVER_HOLD_TICKS)),
        .dec      (tick && (state_q == ST_OVER)),
        .is_zero  (hold_zero)
    );

    // Saturating increment; the collide branch compares high_score against
    // this incremented value so a pass in the crash cycle still counts.
    always_comb begin
        score_inc = score_q;
        if (pipe_passed && (score_q != SCORE_W'(SCORE_MAX))) begin
            score_inc = score_q + 1'b1;
        end
    end

    always_comb begin
        state_n   = state_q;
        score_n   = score_q;
        high_n    = high_q;
        flap_n    = 1'b0;
        clear_n   = 1'b0;
        cd_load   = 1'b0;
        cd_clr    = 1'b0;
        hold_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_n = ST_PLAY;
                    clear_n = 1'b1;
                    score_n = '0;
                end
            end
            ST_PLAY: begin
                score_n = score_inc;
                if (collide) begin
                    state_n   = ST_OVER;
                    hold_load = 1'b1;
                    if (score_inc > high_q) begin
                        high_n = score_inc;
                    end
                end else if (pause_pulse) begin
                    state_n = ST_PAUSE;
                end else if (flap_pulse && cd_zero) begin
                    flap_n  = 1'b1;
                    cd_load = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (pause_pulse || start_pulse) begin
                    state_n = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_pulse && hold_zero) begin
                    state_n = ST_PLAY;
                    clear_n = 1'b1;
                    score_n = '0;
                    cd_clr  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            high_q  <= '0;
            flap_q  <= 1'b0;
            clear_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            score_q <= score_n;
            high_q  <= high_n;
            flap_q  <= flap_n;
            clear_q <= clear_n;
            run_q   <= (state_n == ST_PLAY);
        end
    end

    assign state       = state_q;
    assign run_en      = run_q;
    assign flap_req    = flap_q;
    assign clear_world = clear_q;
    assign score       = score_q;
    assign high_score  = high_q;

endmodule
